// File: rtl/freq_meter_pkg.sv
// Shared types and default widths for the Fdiv frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned GATE_W_DEF      = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Saturation value of an edge counter at the default width.
  localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;

endpackage

// File: rtl/freq_meter_if.sv
// Measurement request/result bundle between a calibration controller and freq_meter.
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned GATE_W = GATE_W_DEF
) ();

  logic              Start;
  logic [GATE_W-1:0] Gate_cycles;
  logic              Busy;
  logic              Valid;
  logic [CNT_W-1:0]  Count;
  logic              Ovf;

  modport master (
    output Start, Gate_cycles,
    input  Busy, Valid, Count, Ovf
  );

  modport slave (
    input  Start, Gate_cycles,
    output Busy, Valid, Count, Ovf
  );

endinterface

// File: rtl/freq_meter_edge_sync.sv
// Synchronises an asynchronous input into Clk and flags its rising edges
// with a single-cycle pulse. Latency from Din to Rise being counted is
// SYNC_STAGES+1 cycles.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Din,
  output logic Rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Metastability chain followed by a history flop for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign Rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronised Fdiv rising edges over a window of
// Gate_cycles Clk cycles and reports the result with a one-cycle Valid pulse.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned GATE_W      = GATE_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Fdiv,
  freq_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  logic              rise;
  state_e            state_q;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic              ovf_int_q;
  logic              busy_q;
  logic              valid_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .Din   (Fdiv),
    .Rise  (rise)
  );

  // Measurement FSM with window/edge counters; Busy and Valid are registered
  // alongside the state so they line up with IDLE/MEAS/DONE occupancy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_int_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            gate_cnt_q <= bus.Gate_cycles;
            edge_cnt_q <= '0;
            ovf_int_q  <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.Gate_cycles == '0) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= MEAS;
            end
          end
        end
        MEAS: begin
          if (rise) begin
            if (edge_cnt_q == CNT_MAX) ovf_int_q  <= 1'b1;
            else                       edge_cnt_q <= edge_cnt_q + 1'b1;
          end
          gate_cnt_q <= gate_cnt_q - 1'b1;
          if (gate_cnt_q == GATE_ONE) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          count_q <= edge_cnt_q;
          ovf_q   <= ovf_int_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy  = busy_q;
  assign bus.Valid = valid_q;
  assign bus.Count = count_q;
  assign bus.Ovf   = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a 16-bit and an 8-bit instance share
// Clk, Reset and a behavioural Fdiv generator.
module tb_freq_meter;
  import freq_meter_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  logic Fdiv;

  int errors = 0;
  int checks = 0;

  // Fdiv generator control: mode 0 toggles, 1 holds low, 2 holds high.
  int hi_cyc = 5;
  int lo_cyc = 5;
  int fmode  = 0;

  freq_meter_if #(.CNT_W(16), .GATE_W(16)) bus16 ();
  freq_meter_if #(.CNT_W(8),  .GATE_W(16)) bus8  ();

  freq_meter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) dut16 (
    .Clk(Clk), .Reset(Reset), .Fdiv(Fdiv), .bus(bus16)
  );

  freq_meter #(.CNT_W(8), .GATE_W(16), .SYNC_STAGES(2)) dut8 (
    .Clk(Clk), .Reset(Reset), .Fdiv(Fdiv), .bus(bus8)
  );

  always #5 Clk = ~Clk;

  // Fdiv edges land 3 ns into a 10 ns Clk period, never on a Clk edge.
  initial begin
    Fdiv = 1'b0;
    #3;
    forever begin
      if (fmode == 0) begin
        Fdiv = 1'b1;
        #(hi_cyc * 10);
        Fdiv = 1'b0;
        #(lo_cyc * 10);
      end else begin
        Fdiv = (fmode == 2);
        #10;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_start(input bit sel8, input logic s, input int g);
    if (sel8) begin
      bus8.Start = s;  bus8.Gate_cycles = 16'(g);
    end else begin
      bus16.Start = s; bus16.Gate_cycles = 16'(g);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  // Issues one Start and observes Busy/Valid for each cycle after the
  // accepting edge, returning Count/Ovf one cycle after the Valid slot.
  task automatic measure(input bit sel8, input int g, input bit repulse,
                         output int valid_at, output int valid_cnt,
                         output bit busy_ok, output int cnt, output bit ovf);
    logic b, v;
    valid_at = -1; valid_cnt = 0; busy_ok = 1'b1; cnt = 0; ovf = 1'b0;
    @(negedge Clk);
    set_start(sel8, 1'b1, g);
    @(posedge Clk);
    for (int n = 0; n <= g + 1; n++) begin
      @(negedge Clk);
      // Scramble Gate_cycles after acceptance; it must have no effect.
      set_start(sel8, repulse && (n == 4 || n == 499), (g ^ 16'h5A5A) & 16'hFFFF);
      b = sel8 ? bus8.Busy  : bus16.Busy;
      v = sel8 ? bus8.Valid : bus16.Valid;
      if (b !== (n <= g)) busy_ok = 1'b0;
      if (v === 1'b1) begin
        valid_cnt++;
        if (valid_at < 0) valid_at = n;
      end
    end
    cnt = sel8 ? int'(bus8.Count) : int'(bus16.Count);
    ovf = sel8 ? bus8.Ovf : bus16.Ovf;
    set_start(sel8, 1'b0, 0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_start(1'b0, 1'b0, 0);
    set_start(1'b1, 1'b0, 0);
    wait_cycles(4);
    checks++; if ({bus16.Busy, bus16.Valid, bus16.Ovf} !== 3'b000) begin errors++;
      $display("FAIL reset_flags16: got %b expected 000", {bus16.Busy, bus16.Valid, bus16.Ovf}); end
    checks++; if (bus16.Count !== 16'd0) begin errors++;
      $display("FAIL reset_count16: got %0d expected 0", bus16.Count); end
    checks++; if ({bus8.Busy, bus8.Valid, bus8.Ovf} !== 3'b000) begin errors++;
      $display("FAIL reset_flags8: got %b expected 000", {bus8.Busy, bus8.Valid, bus8.Ovf}); end
    checks++; if (bus8.Count !== 8'd0) begin errors++;
      $display("FAIL reset_count8: got %0d expected 0", bus8.Count); end
    Reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_basic();
    int va, vc, c; bit bo, o;
    fmode = 0; hi_cyc = 5; lo_cyc = 5;
    wait_cycles(50);
    measure(1'b0, 1000, 1'b0, va, vc, bo, c, o);
    checks++; if (va !== 1000 || vc !== 1) begin errors++;
      $display("FAIL basic_valid: got at=%0d n=%0d expected at=1000 n=1", va, vc); end
    checks++; if (!bo) begin errors++; $display("FAIL basic_busy: got wrong Busy window expected cycles 0..1000"); end
    checks++; if (c < 99 || c > 101) begin errors++;
      $display("FAIL basic_count: got %0d expected 99..101", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", o); end
  endtask

  task automatic test_zero_gate();
    int va, vc, c; bit bo, o;
    measure(1'b0, 0, 1'b0, va, vc, bo, c, o);
    checks++; if (va !== 0 || vc !== 1) begin errors++;
      $display("FAIL zero_valid: got at=%0d n=%0d expected at=0 n=1", va, vc); end
    checks++; if (!bo) begin errors++; $display("FAIL zero_busy: got wrong Busy window expected one cycle"); end
    checks++; if (c !== 0 || o !== 1'b0) begin errors++;
      $display("FAIL zero_result: got count=%0d ovf=%b expected 0/0", c, o); end
  endtask

  task automatic test_saturation();
    int va, vc, c; bit bo, o;
    hi_cyc = 2; lo_cyc = 2;
    wait_cycles(60);
    measure(1'b1, 2000, 1'b0, va, vc, bo, c, o);
    checks++; if (c !== 255 || o !== 1'b1) begin errors++;
      $display("FAIL sat_result: got count=%0d ovf=%b expected 255/1", c, o); end
    checks++; if (va !== 2000 || vc !== 1) begin errors++;
      $display("FAIL sat_valid: got at=%0d n=%0d expected at=2000 n=1", va, vc); end
    hi_cyc = 10; lo_cyc = 10;
    wait_cycles(60);
    measure(1'b1, 1000, 1'b0, va, vc, bo, c, o);
    checks++; if (c < 49 || c > 51 || o !== 1'b0) begin errors++;
      $display("FAIL sat_recover: got count=%0d ovf=%b expected 49..51/0", c, o); end
  endtask

  task automatic test_back_to_back();
    int va, vc, c, extra_v, extra_b; bit bo, o;
    hi_cyc = 5; lo_cyc = 5;
    wait_cycles(60);
    measure(1'b0, 1000, 1'b1, va, vc, bo, c, o);
    checks++; if (va !== 1000 || vc !== 1 || !bo) begin errors++;
      $display("FAIL b2b_valid: got at=%0d n=%0d busy_ok=%0b expected at=1000 n=1 busy_ok=1", va, vc, bo); end
    checks++; if (c < 99 || c > 101) begin errors++;
      $display("FAIL b2b_count: got %0d expected 99..101", c); end
    extra_v = 0; extra_b = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge Clk);
      if (bus16.Valid === 1'b1) extra_v++;
      if (bus16.Busy  === 1'b1) extra_b++;
    end
    checks++; if (extra_v !== 0 || extra_b !== 0) begin errors++;
      $display("FAIL b2b_no_second: got valid=%0d busy=%0d expected 0/0", extra_v, extra_b); end
  endtask

  task automatic test_reset_abort();
    int va, vc, c, late_v; bit bo, o;
    @(negedge Clk);
    set_start(1'b0, 1'b1, 1000);
    @(posedge Clk);
    @(negedge Clk);
    set_start(1'b0, 1'b0, 0);
    wait_cycles(299);
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (bus16.Busy !== 1'b0 || bus16.Valid !== 1'b0) begin errors++;
      $display("FAIL abort_busy: got busy=%b valid=%b expected 0/0", bus16.Busy, bus16.Valid); end
    checks++; if (bus16.Count !== 16'd0 || bus16.Ovf !== 1'b0) begin errors++;
      $display("FAIL abort_count: got count=%0d ovf=%b expected 0/0", bus16.Count, bus16.Ovf); end
    Reset = 1'b0;
    late_v = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (bus16.Valid === 1'b1) late_v++;
    end
    checks++; if (late_v !== 0) begin errors++;
      $display("FAIL abort_no_valid: got %0d Valid pulses expected 0", late_v); end
    measure(1'b0, 1000, 1'b0, va, vc, bo, c, o);
    checks++; if (va !== 1000 || c < 99 || c > 101) begin errors++;
      $display("FAIL abort_restart: got at=%0d count=%0d expected 1000 and 99..101", va, c); end
  endtask

  task automatic test_const();
    int va, vc, c; bit bo, o;
    for (int m = 1; m <= 2; m++) begin
      fmode = m;
      wait_cycles(40);
      measure(1'b0, 500, 1'b0, va, vc, bo, c, o);
      checks++; if (va !== 500 || vc !== 1 || c !== 0 || o !== 1'b0) begin errors++;
        $display("FAIL const_level%0d: got at=%0d count=%0d ovf=%b expected 500/0/0", m - 1, va, c, o); end
    end
    fmode = 0;
  endtask

  // Random periods and windows. A P-periodic edge train sampled over G
  // consecutive cycles holds floor(G/P) or ceil(G/P) edges; the counter
  // then reports min(n, max) and flags overflow once n exceeds max.
  task automatic test_random();
    int va, vc, c, g, p, lo_e, hi_e, maxv; bit bo, o, ok, sel8;
    for (int it = 0; it < 8; it++) begin
      hi_cyc = int'($urandom_range(2, 20));
      lo_cyc = int'($urandom_range(2, 20));
      g      = int'($urandom_range(1, 3000));
      sel8   = 1'(it % 2);
      p      = hi_cyc + lo_cyc;
      maxv   = sel8 ? 255 : 65535;
      wait_cycles(100);
      measure(sel8, g, 1'b0, va, vc, bo, c, o);
      lo_e = g / p;
      hi_e = (g + p - 1) / p;
      ok = 1'b0;
      for (int n = lo_e; n <= hi_e; n++)
        if (c == ((n > maxv) ? maxv : n) && o == (n > maxv)) ok = 1'b1;
      checks++; if (!ok || va !== g || vc !== 1 || !bo) begin errors++;
        $display("FAIL random%0d: got count=%0d ovf=%b at=%0d n=%0d busy_ok=%0b expected count %0d..%0d at=%0d (G=%0d P=%0d w8=%0b)",
                 it, c, o, va, vc, bo, lo_e, hi_e, g, g, p, sel8); end
    end
  endtask

  initial begin
    Reset = 1'b1;
    set_start(1'b0, 1'b0, 0);
    set_start(1'b1, 1'b0, 0);
    test_reset();
    test_basic();
    test_zero_gate();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    test_const();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
